// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte register file; define I2C_TARGET_GLITCH_FILTER_EN for 3-sample majority filtering of SCL/SDA.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int NUM_REGS = 16,
    localparam int PW = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          scl_oe,
    output logic          sda_oe,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_scl_s, r_sda_s;
    logic          r_scl_d, r_sda_d;
    logic          w_scl, w_sda;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_rx_done;
    logic          r_sda_oe, w_oe_nxt;
    logic          w_clr_cnt, w_ld_ptr, w_wr, w_inc_ptr, w_ld_tx;
    logic [3:0]    r_cnt;
    logic [7:0]    r_sh, r_tx, r_wr_data, w_rd_byte;
    logic [PW-1:0] r_ptr, r_wr_addr;
    logic          r_ack, r_wr_strobe;
    logic [2:0]    w_bit_idx;
    logic [7:0]    r_regs [NUM_REGS];

    // two-flop synchronisers, idle-high after reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scl_s <= 2'b11;
            r_sda_s <= 2'b11;
        end else begin
            r_scl_s <= {r_scl_s[0], scl_in};
            r_sda_s <= {r_sda_s[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] r_scl_h, r_sda_h;
    logic       r_scl_m, r_sda_m;
    // majority of the current and two previous samples; single-cycle pulses never win
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scl_h <= 2'b11;
            r_sda_h <= 2'b11;
            r_scl_m <= 1'b1;
            r_sda_m <= 1'b1;
        end else begin
            r_scl_h <= {r_scl_h[0], r_scl_s[1]};
            r_sda_h <= {r_sda_h[0], r_sda_s[1]};
            r_scl_m <= (r_scl_s[1] & r_scl_h[0]) | (r_scl_s[1] & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[1]);
            r_sda_m <= (r_sda_s[1] & r_sda_h[0]) | (r_sda_s[1] & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[1]);
        end
    end
    assign w_scl = r_scl_m;
    assign w_sda = r_sda_m;
`else
    assign w_scl = r_scl_s[1];
    assign w_sda = r_sda_s[1];
`endif

    // previous line levels for edge and START/STOP detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_rx_done  = w_scl_fall & (r_cnt == 4'd8);
    assign w_rd_byte  = r_regs[r_ptr];
    assign w_bit_idx  = 3'd7 - r_cnt[2:0];

    // state and SDA driver registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sda_oe <= w_oe_nxt;
        end
    end

    // next state, SDA drive and datapath controls; byte boundaries act on SCL falls
    always_comb begin
        w_state_nxt = r_state;
        w_oe_nxt    = r_sda_oe;
        w_clr_cnt   = 1'b0;
        w_ld_ptr    = 1'b0;
        w_wr        = 1'b0;
        w_inc_ptr   = 1'b0;
        w_ld_tx     = 1'b0;
        if (w_stop) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt = ADDR;
            w_oe_nxt    = 1'b0;
            w_clr_cnt   = 1'b1;
        end else begin
            case (r_state)
                ADDR: if (w_rx_done) begin
                    w_state_nxt = (r_sh[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                    w_oe_nxt    = (r_sh[7:1] == DEV_ADDR);
                end
                ADDR_ACK: if (w_scl_fall) begin
                    w_clr_cnt   = 1'b1;
                    w_ld_tx     = r_sh[0];
                    w_state_nxt = r_sh[0] ? RDATA : PTR;
                    w_oe_nxt    = r_sh[0] & ~w_rd_byte[7];
                end
                PTR: if (w_rx_done) begin
                    w_ld_ptr    = 1'b1;
                    w_state_nxt = PTR_ACK;
                    w_oe_nxt    = 1'b1;
                end
                WDATA: if (w_rx_done) begin
                    w_wr        = 1'b1;
                    w_state_nxt = WDATA_ACK;
                    w_oe_nxt    = 1'b1;
                end
                PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                    w_clr_cnt   = 1'b1;
                    w_state_nxt = WDATA;
                    w_oe_nxt    = 1'b0;
                end
                RDATA: if (w_scl_fall) begin
                    w_inc_ptr   = (r_cnt == 4'd8);
                    w_state_nxt = (r_cnt == 4'd8) ? RDATA_ACK : RDATA;
                    w_oe_nxt    = (r_cnt == 4'd8) ? 1'b0 : ~r_tx[w_bit_idx];
                end
                RDATA_ACK: if (w_scl_fall) begin
                    w_clr_cnt   = r_ack;
                    w_ld_tx     = r_ack;
                    w_state_nxt = r_ack ? RDATA : WAIT_STOP;
                    w_oe_nxt    = r_ack & ~w_rd_byte[7];
                end
                default: ;
            endcase
        end
    end

    // bit counter, shifter, pointer, register file and write reporting
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_sh        <= '0;
            r_tx        <= '0;
            r_ack       <= 1'b0;
            r_ptr       <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= w_wr;
            if (w_clr_cnt)
                r_cnt <= '0;
            else if (w_scl_rise && (r_state inside {ADDR, PTR, WDATA, RDATA}))
                r_cnt <= r_cnt + 4'd1;
            if (w_scl_rise && (r_state inside {ADDR, PTR, WDATA}))
                r_sh <= {r_sh[6:0], w_sda};
            if (w_scl_rise && r_state == RDATA_ACK)
                r_ack <= ~w_sda;
            if (w_ld_ptr)
                r_ptr <= r_sh[PW-1:0];
            else if (w_wr || w_inc_ptr)
                r_ptr <= r_ptr + 1'b1;
            if (w_wr) begin
                r_regs[r_ptr] <= r_sh;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= r_sh;
            end
            if (w_ld_tx)
                r_tx <= w_rd_byte;
        end
    end

    assign scl_oe    = 1'b0;
    assign sda_oe    = r_sda_oe;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_state inside {ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK};
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bit-banged I2C master driving i2c_target_regs.
module tb_i2c_target_regs;
    localparam int Q = 10;
    logic       clk = 1'b0, reset_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_oe, sda_oe, wr_strobe, busy, sda_line, scl_line;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    int         total = 0, bad = 0, n_wr = 0, n_start = 0;
    logic [3:0] lg_a [8];
    logic [7:0] lg_d [8];
    logic       oe_seen = 1'b0, busy_seen = 1'b0;
    logic       a0, a1, a2, a3;
    logic [7:0] d0, d1;

    assign sda_line = m_sda & ~sda_oe;
    assign scl_line = m_scl & ~scl_oe;

    i2c_target_regs dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_line), .sda_in(sda_line),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            if (n_wr < 8) begin
                lg_a[n_wr] = wr_addr;
                lg_d[n_wr] = wr_data;
            end
            n_wr++;
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (dut.w_start) n_start++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_c();
        m_sda = 1'b1; half();
        m_scl = 1'b1; half();
        m_sda = 1'b0; half();
        m_scl = 1'b0; half();
    endtask

    task automatic stop_c();
        m_sda = 1'b0; half();
        m_scl = 1'b1; half();
        m_sda = 1'b1; half();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            m_sda = b[7-i]; half();
            m_scl = 1'b1; half();
            m_scl = 1'b0; half();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; half();
        m_scl = 1'b1; half();
        ack = ~sda_line;
        m_scl = 1'b0; half();
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        d = '0;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            half();
            m_scl = 1'b1; half();
            d = {d[6:0], sda_line};
            m_scl = 1'b0;
        end
        m_sda = ~ack; half();
        m_scl = 1'b1; half();
        m_scl = 1'b0; half();
        m_sda = 1'b1;
    endtask

    task automatic read_two(input logic [7:0] ptr, output logic [7:0] x, output logic [7:0] y);
        logic k;
        start_c(); write_byte(8'hA0, k); write_byte(ptr, k);
        start_c(); write_byte(8'hA1, k);
        read_byte(1'b1, x); read_byte(1'b0, y);
        stop_c();
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_scl_oe", 32'(scl_oe), 32'd0);
        chk("rst_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        reset_n = 1'b1;
        half();

        // write 0x5A, 0xC3 starting at register 3
        start_c();
        write_byte(8'hA0, a0); write_byte(8'h03, a1); write_byte(8'h5A, a2); write_byte(8'hC3, a3);
        stop_c();
        chk("wr_ack_addr", 32'(a0), 32'd1);
        chk("wr_ack_ptr", 32'(a1), 32'd1);
        chk("wr_ack_d0", 32'(a2), 32'd1);
        chk("wr_ack_d1", 32'(a3), 32'd1);
        chk("wr_count", 32'(n_wr), 32'd2);
        chk("wr0_addr", 32'(lg_a[0]), 32'd3);
        chk("wr0_data", 32'(lg_d[0]), 32'h5A);
        chk("wr1_addr", 32'(lg_a[1]), 32'd4);
        chk("wr1_data", 32'(lg_d[1]), 32'hC3);
        chk("wr_busy_after_stop", 32'(busy), 32'd0);

        // read back through a repeated START
        read_two(8'h03, d0, d1);
        chk("rd_byte0", 32'(d0), 32'h5A);
        chk("rd_byte1", 32'(d1), 32'hC3);
        chk("rd_busy_after_stop", 32'(busy), 32'd0);
        chk("rd_oe_after_stop", 32'(sda_oe), 32'd0);

        // address mismatch
        n_wr = 0; oe_seen = 1'b0; busy_seen = 1'b0;
        start_c(); write_byte(8'hA2, a0); write_byte(8'h00, a1); stop_c();
        chk("mm_ack_addr", 32'(a0), 32'd0);
        chk("mm_ack_data", 32'(a1), 32'd0);
        chk("mm_oe_seen", 32'(oe_seen), 32'd0);
        chk("mm_busy_seen", 32'(busy_seen), 32'd0);
        chk("mm_wr_count", 32'(n_wr), 32'd0);

        // pointer wrap on write and read
        n_wr = 0;
        start_c(); write_byte(8'hA0, a0); write_byte(8'h0F, a1); write_byte(8'h11, a2); write_byte(8'h22, a3); stop_c();
        chk("wrap_wr_count", 32'(n_wr), 32'd2);
        chk("wrap_wr0_addr", 32'(lg_a[0]), 32'd15);
        chk("wrap_wr1_addr", 32'(lg_a[1]), 32'd0);
        chk("wrap_wr1_data", 32'(lg_d[1]), 32'h22);
        read_two(8'h0F, d0, d1);
        chk("wrap_rd15", 32'(d0), 32'h11);
        chk("wrap_rd0", 32'(d1), 32'h22);

        // STOP after 4 data bits
        n_wr = 0;
        start_c(); write_byte(8'hA0, a0); write_byte(8'h05, a1); send_bits(8'hF0, 4); stop_c();
        chk("abort_wr_count", 32'(n_wr), 32'd0);
        read_two(8'h05, d0, d1);
        chk("abort_reg5", 32'(d0), 32'h00);
        chk("abort_reg6", 32'(d1), 32'h00);

        // reset while the target is acknowledging a read address
        start_c(); write_byte(8'hA0, a0); write_byte(8'h03, a1);
        start_c(); send_bits(8'hA1, 8);
        m_sda = 1'b1; half();
        m_scl = 1'b1; half();
        chk("rst_ack_driving", 32'(sda_oe), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_ack_released", 32'(sda_oe), 32'd0);
        chk("rst_ack_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        m_scl = 1'b0; half();
        stop_c();
        read_two(8'h03, d0, d1);
        chk("rst_reg3_cleared", 32'(d0), 32'h00);
        chk("rst_reg4_cleared", 32'(d1), 32'h00);

        // one-cycle SDA low pulse with SCL high
        half();
        n_start = 0; busy_seen = 1'b0;
        m_sda = 1'b0;
        @(negedge clk);
        m_sda = 1'b1;
        half(); half();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        chk("glitch_start", 32'(n_start), 32'd0);
`else
        chk("glitch_start", 32'(n_start), 32'd1);
`endif
        chk("glitch_busy", 32'(busy_seen), 32'd0);
        chk("glitch_oe", 32'(sda_oe), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit I2C target address.
REQ-002 SHALL have parameter NUM_REGS, default 16, the register count; it is a power of two between 2 and 256, and PW = log2(NUM_REGS).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; it runs at least 16x the SCL rate.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port scl_in, input, 1 bit: raw SCL pad level, asynchronous to clk.
REQ-006 SHALL have port sda_in, input, 1 bit: raw SDA pad level, asynchronous to clk.
REQ-007 SHALL have port scl_oe, output, 1 bit: drive SCL low when 1; it is tied to 0 (no clock stretching).
REQ-008 SHALL have port sda_oe, output, 1 bit: drive SDA low when 1 (open-drain).
REQ-009 SHALL have port wr_strobe, output, 1 bit: one-cycle pulse on each completed data-byte write.
REQ-010 SHALL have port wr_addr, output, PW bits: register index of the last write.
REQ-011 SHALL have port wr_data, output, 8 bits: data value of the last write.
REQ-012 SHALL have port busy, output, 1 bit: high from an addressed START until STOP, NACK, or an address mismatch.

Function
REQ-013 SHALL synchronise scl_in and sda_in through 2 flops each before any use.
REQ-014 SHALL detect START as a synchronised SDA falling edge while SCL is high, and STOP as an SDA rising edge while SCL is high.
REQ-015 SHALL sample SDA on each synchronised SCL rising edge and change sda_oe only on the cycle after a synchronised SCL falling edge.
REQ-016 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-017 SHALL go to ADDR on START from any state, including repeated START, with the bit counter cleared.
REQ-018 SHALL go to IDLE on STOP from any state and release sda_oe within 1 cycle.
REQ-019 ADDR SHALL shift in 8 bits MSB-first; on a match to DEV_ADDR it goes to ADDR_ACK, otherwise to WAIT_STOP without driving SDA.
REQ-020 ADDR_ACK SHALL drive sda_oe=1 for one SCL period, then go to PTR if R/W=0, or to RDATA if R/W=1.
REQ-021 PTR SHALL load the received byte, masked to PW LSBs, into the pointer, ACK it, then go to WDATA.
REQ-022 WDATA SHALL write the byte to regs[ptr], pulse wr_strobe with wr_addr=ptr and wr_data=byte, ACK it, and increment ptr.
REQ-023 RDATA SHALL drive regs[ptr] MSB-first (sda_oe = ~bit), release SDA in RDATA_ACK, then increment ptr.
REQ-024 In RDATA_ACK, a master ACK SHALL send the next byte and a master NACK SHALL go to WAIT_STOP.
REQ-025 The pointer SHALL wrap from NUM_REGS-1 to 0 on reads and writes.
REQ-026 A START or STOP mid-byte SHALL discard the partial byte, leaving no register write and no wr_strobe.
REQ-027 On a read, the byte SHALL be latched from regs[ptr] at ADDR_ACK or RDATA_ACK exit, so the data is stable during the byte.

Reset
REQ-028 When reset_n=0 at a clk edge, the FSM SHALL go to IDLE; sda_oe, scl_oe, wr_strobe, busy, wr_addr, wr_data, ptr and all regs SHALL be 0, and the synchronisers SHALL be 1.
REQ-029 A reset mid-transaction SHALL release SDA immediately, and the block SHALL ignore the bus until the next START.

Configuration
REQ-030 With I2C_TARGET_GLITCH_FILTER_EN defined, each synchronised line SHALL pass a 3-sample majority filter, adding 2 cycles of latency and rejecting pulses of 1 cycle or less.
REQ-031 Without I2C_TARGET_GLITCH_FILTER_EN, no filter SHALL be present and the lines SHALL be used directly after the 2-flop synchronisers.

Verification
REQ-032 Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; wr_strobe twice, with (3,0x5A) then (4,0xC3); regs[3]=0x5A and regs[4]=0xC3.
REQ-033 Read: START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> SDA carries 0x5A then 0xC3; the FSM is in IDLE after STOP.
REQ-034 Address mismatch: START, 0xA2, 0x00, STOP -> sda_oe stays 0 throughout; no wr_strobe; busy stays 0.
REQ-035 Wrap: write pointer 0x0F then 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22.
REQ-036 Abort: STOP after 4 data bits of a write -> no wr_strobe and the register is unchanged; reset_n low during a read ACK -> sda_oe=0 on the next cycle.
REQ-037 Filter: with the macro defined, a 1-cycle SDA low pulse while SCL is high -> no START is detected; without the macro, the same pulse is detected as START.
